// File: rtl/input_port_requester.sv
// Input-port requester for a 4-way round-robin output arbiter.
//
// Buffers incoming packets in a small FIFO, decodes the head packet's destination
// (top two bits) into a one-hot request, holds that request until a matching grant
// arrives, then pops the head and forwards it with a one-cycle out_valid pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  upstream packet valid
//   in_ready  block can accept a packet this cycle (low while in reset)
//   in_data   upstream packet
//   req       registered one-hot request toward the arbiter
//   grant     one-hot grant from the arbiter
//   out_valid forwarded packet valid, one-cycle pulse per packet
//   out_data  forwarded packet, held until the next send
//   count     FIFO occupancy, 0..DEPTH
module input_port_requester #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        req,
  input  logic [3:0]        grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W-1:0] PtrOne = 1;
  localparam logic [PTR_W:0]   CntOne = 1;

  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic [3:0]          req_q, req_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                full, empty, push, pop;
  logic [DATA_W-1:0]   head;
  logic [1:0]          head_dest;
  logic [3:0]          head_onehot;

  // DEPTH is a power of two, so occupancy == DEPTH exactly when the MSB is set.
  assign full        = count_q[PTR_W];
  assign empty       = (count_q == '0);
  assign in_ready    = !full && rst_n;
  assign push        = in_valid && in_ready;
  assign head        = mem_q[rd_ptr_q];
  assign head_dest   = head[DATA_W-1 -: 2];
  assign head_onehot = 4'b0001 << head_dest;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_d = 4'b0000;
        if (!empty) begin
          state_d = StReq;
          req_d   = head_onehot;
        end
      end
      StReq: begin
        // Grant bits outside the current request are ignored.
        if ((grant & req_q) != 4'b0000) begin
          state_d     = StSend;
          out_data_d  = head;
          out_valid_d = 1'b1;
          pop         = 1'b1;
          req_d       = 4'b0000;
        end
      end
      StSend: begin
        // req stays low for this cycle so the arbiter pointer can advance.
        if (!empty) begin
          state_d = StReq;
          req_d   = head_onehot;
        end else begin
          state_d = StIdle;
          req_d   = 4'b0000;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_q       <= 4'b0000;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_q       <= req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign req       = req_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_input_port_requester.sv
module tb_input_port_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb [$];

  input_port_requester #(.DATA_W(64), .DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pkt(input logic [1:0] d, input int id);
    return {d, 14'h2ab5, 16'hc0de, 32'(id)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push attempt; expected output is queued only if accepted and wanted.
  task automatic push(input logic [63:0] data, input bit expect_out);
    bit acc;
    in_valid = 1'b1;
    in_data  = data;
    acc      = in_ready;
    if (acc && expect_out) sb.push_back(data);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got data %h expected no output", out_data);
      end else begin
        check("out_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int guard;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = pkt(2'd1, 99);
    grant    = 4'b0000;

    // 1. Reset with in_valid asserted
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // 2. Single packet, dest 2, grant tied high
    grant = 4'b0100;
    push(pkt(2'd2, 1), 1'b1);
    check("t2_count_after_push", 64'(count), 64'd1);
    check("t2_req_at_push", 64'(req), 64'd0);
    tick();
    check("t2_req", 64'(req), 64'h4);
    tick();
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_count", 64'(count), 64'd0);
    check("t2_req_drop", 64'(req), 64'd0);
    tick();
    check("t2_out_valid_pulse", 64'(out_valid), 64'd0);
    grant = 4'b0000;
    tick();

    // 3. Fill to full, refuse 5th, then drain in order
    for (int d = 0; d < 4; d++) push(pkt(2'(d), 10 + d), 1'b1);
    check("t3_count_full", 64'(count), 64'd4);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_req_held", 64'(req), 64'h1);
    push(pkt(2'd3, 77), 1'b1);
    check("t3_count_refuse", 64'(count), 64'd4);
    check("t3_req_still", 64'(req), 64'h1);
    grant = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      check("t3_req_seq", 64'(req), 64'(4'b0001 << k));
      tick();
      check("t3_send_valid", 64'(out_valid), 64'd1);
      check("t3_send_req0", 64'(req), 64'd0);
      tick();
    end
    check("t3_count_end", 64'(count), 64'd0);
    check("t3_req_end", 64'(req), 64'd0);

    // 4. Mismatched grant is ignored
    grant = 4'b0000;
    push(pkt(2'd1, 20), 1'b1);
    tick();
    check("t4_req", 64'(req), 64'h2);
    grant = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_req_hold", 64'(req), 64'h2);
      check("t4_no_pop", 64'(count), 64'd1);
    end
    grant = 4'b0010;
    tick();
    check("t4_send", 64'(out_valid), 64'd1);
    grant = 4'b0000;
    tick();
    check("t4_count", 64'(count), 64'd0);
    check("t4_req_idle", 64'(req), 64'd0);

    // 5. Push/pop on the SEND edge at count 2, nine packets through the wrap
    push(pkt(2'd3, 30), 1'b1);
    push(pkt(2'd0, 31), 1'b1);
    check("t5_count2", 64'(count), 64'd2);
    check("t5_req", 64'(req), 64'h8);
    grant    = 4'b1111;
    in_valid = 1'b1;
    in_data  = pkt(2'd1, 32);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(in_data);
    tick();
    in_valid = 1'b0;
    check("t5_count_same", 64'(count), 64'd2);
    check("t5_out_valid", 64'(out_valid), 64'd1);
    idx   = 3;
    guard = 0;
    while (idx < 9 && guard < 100) begin
      in_valid = 1'b1;
      in_data  = pkt(2'(idx % 4), 30 + idx);
      if (in_ready) begin
        sb.push_back(in_data);
        idx++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("t5_all_pushed", 64'(idx), 64'd9);
    guard = 0;
    while ((count != 0 || req != 0) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check("t5_drained", 64'(count), 64'd0);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6. Reset while requesting discards everything
    grant = 4'b0000;
    push(pkt(2'd2, 40), 1'b0);
    push(pkt(2'd0, 41), 1'b0);
    push(pkt(2'd1, 42), 1'b0);
    check("t6_count3", 64'(count), 64'd3);
    check("t6_req", 64'(req), 64'h4);
    rst_n = 1'b0;
    tick();
    check("t6_req_rst", 64'(req), 64'd0);
    check("t6_count_rst", 64'(count), 64'd0);
    rst_n = 1'b1;
    grant = 4'b1111;
    for (int k = 0; k < 10; k++) tick();
    check("t6_no_req", 64'(req), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
